// File: rtl/temperature_supervisor.sv
// Temperature supervisor: 4-sample moving average feeding a hysteresis/persistence
// zone classifier that drives the fan level and a latched over-temperature alarm.
module temperature_supervisor #(
  parameter logic [7:0] WARM_ON  = 8'd40,
  parameter logic [7:0] WARM_OFF = 8'd36,
  parameter logic [7:0] HOT_ON   = 8'd60,
  parameter logic [7:0] HOT_OFF  = 8'd55,
  parameter logic [7:0] CRIT_ON  = 8'd80,
  parameter logic [7:0] CRIT_OFF = 8'd75,
  parameter int         PERSIST  = 3
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       sampleValid,
  input  logic [7:0] temperature,
  input  logic       alarmAck,
  output logic [7:0] filtTemp,
  output logic       filtValid,
  output logic [1:0] zone,
  output logic [1:0] fanLevel,
  output logic       alarm
);

  typedef enum logic [1:0] {
    COOL = 2'd0,
    WARM = 2'd1,
    HOT  = 2'd2,
    CRIT = 2'd3
  } zoneT;

  localparam logic [3:0] PERSIST_CNT = 4'(PERSIST);

  function automatic zoneT levelUp(input logic [7:0] f);
    if (f >= CRIT_ON)      return CRIT;
    else if (f >= HOT_ON)  return HOT;
    else if (f >= WARM_ON) return WARM;
    else                   return COOL;
  endfunction

  function automatic zoneT levelDn(input logic [7:0] f);
    if (f < WARM_OFF)      return COOL;
    else if (f < HOT_OFF)  return WARM;
    else if (f < CRIT_OFF) return HOT;
    else                   return CRIT;
  endfunction

  // ---- stage p0: sample window and running sum
  logic [7:0] winP0 [4];
  logic [9:0] sumP0;
  logic [2:0] fillCnt;
  logic       vldP0;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      for (int i = 0; i < 4; i++) winP0[i] <= 8'd0;
      sumP0   <= 10'd0;
      fillCnt <= 3'd0;
      vldP0   <= 1'b0;
    end else begin
      vldP0 <= 1'b0;
      if (sampleValid) begin
        winP0[0] <= temperature;
        winP0[1] <= winP0[0];
        winP0[2] <= winP0[1];
        winP0[3] <= winP0[2];
        // Oldest slot is zero until the window fills, so the sum stays exact.
        sumP0    <= sumP0 + {2'b00, temperature} - {2'b00, winP0[3]};
        if (fillCnt != 3'd4) fillCnt <= fillCnt + 3'd1;
        vldP0    <= (fillCnt >= 3'd3);
      end
    end
  end

  // ---- stage p1: registered filter output
  always_ff @(posedge clk) begin
    if (!rstN) begin
      filtTemp  <= 8'd0;
      filtValid <= 1'b0;
    end else begin
      filtValid <= vldP0;
      if (vldP0) filtTemp <= sumP0[9:2];
    end
  end

  // ---- stage p2: zone classifier and alarm
  zoneT       zoneQ, zoneD, pendQ, pendD;
  zoneT       upLvl, dnLvl, target;
  logic [3:0] cntQ, cntD, cntStep;
  logic       alarmQ, alarmD;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      zoneQ  <= COOL;
      pendQ  <= COOL;
      cntQ   <= 4'd0;
      alarmQ <= 1'b0;
    end else begin
      zoneQ  <= zoneD;
      pendQ  <= pendD;
      cntQ   <= cntD;
      alarmQ <= alarmD;
    end
  end

  always_comb begin
    zoneD   = zoneQ;
    pendD   = pendQ;
    cntD    = cntQ;
    alarmD  = alarmQ;
    upLvl   = levelUp(filtTemp);
    dnLvl   = levelDn(filtTemp);
    target  = zoneQ;
    cntStep = cntQ;

    if (filtValid) begin
      if (upLvl > zoneQ)      target = upLvl;
      else if (dnLvl < zoneQ) target = dnLvl;

      if (target == zoneQ) begin
        cntD = 4'd0;
      end else if (target == CRIT) begin
        zoneD = CRIT;
        cntD  = 4'd0;
      end else begin
        if (target != pendQ) begin
          pendD   = target;
          cntStep = 4'd1;
        end else begin
          cntStep = cntQ + 4'd1;
        end
        if (cntStep == PERSIST_CNT) begin
          zoneD = target;
          cntD  = 4'd0;
        end else begin
          cntD  = cntStep;
        end
      end
    end

    // Set wins over a simultaneous ack; ack is ignored while still in CRIT.
    if (zoneD == CRIT && zoneQ != CRIT)  alarmD = 1'b1;
    else if (alarmAck && zoneQ != CRIT)  alarmD = 1'b0;
  end

  assign zone     = zoneQ;
  assign fanLevel = zoneQ;
  assign alarm    = alarmQ;

endmodule

// File: tb/tb_temperature_supervisor.sv
// Bench for temperature_supervisor: directed scenarios plus a random walk, all
// checked every cycle against a queue-based behavioural model of the supervisor.
module tb_temperature_supervisor;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       sampleValid = 1'b0;
  logic [7:0] temperature = 8'd0;
  logic       alarmAck = 1'b0;
  logic [7:0] filtTemp;
  logic       filtValid;
  logic [1:0] zone;
  logic [1:0] fanLevel;
  logic       alarm;

  always #5 clk = ~clk;

  temperature_supervisor dut (
    .clk(clk),
    .rstN(rstN),
    .sampleValid(sampleValid),
    .temperature(temperature),
    .alarmAck(alarmAck),
    .filtTemp(filtTemp),
    .filtValid(filtValid),
    .zone(zone),
    .fanLevel(fanLevel),
    .alarm(alarm)
  );

  localparam int PERSIST = 3;

  int nCmp = 0;
  int nBad = 0;

  // Behavioural model state
  int mWin[$];
  int mAccPrev = 0, mAccVal = 0;
  int mFilt = 0, mValid = 0, mZone = 0, mPend = 0, mCnt = 0, mAlarm = 0;

  function automatic int lvlUp(input int f);
    if (f >= 80) return 3;
    if (f >= 60) return 2;
    if (f >= 40) return 1;
    return 0;
  endfunction

  function automatic int lvlDn(input int f);
    if (f < 36) return 0;
    if (f < 55) return 1;
    if (f < 75) return 2;
    return 3;
  endfunction

  task automatic modelEdge(input logic r, input logic sv, input logic [7:0] t, input logic ack);
    int oldZone;
    int tgt;
    int sum;
    if (!r) begin
      mWin.delete();
      mAccPrev = 0; mAccVal = 0;
      mFilt = 0; mValid = 0; mZone = 0; mPend = 0; mCnt = 0; mAlarm = 0;
      return;
    end
    oldZone = mZone;
    if (mValid != 0) begin
      tgt = mZone;
      if (lvlUp(mFilt) > mZone)      tgt = lvlUp(mFilt);
      else if (lvlDn(mFilt) < mZone) tgt = lvlDn(mFilt);
      if (tgt == mZone) mCnt = 0;
      else if (tgt == 3) begin
        mZone = 3; mCnt = 0;
      end else begin
        if (tgt != mPend) begin
          mPend = tgt; mCnt = 1;
        end else mCnt++;
        if (mCnt >= PERSIST) begin
          mZone = tgt; mCnt = 0;
        end
      end
    end
    if (mZone == 3 && oldZone != 3) mAlarm = 1;
    else if (ack && oldZone != 3)   mAlarm = 0;
    mValid = mAccPrev;
    if (mAccPrev != 0) mFilt = mAccVal;
    mAccPrev = 0;
    if (sv) begin
      mWin.push_back(int'(t));
      if (mWin.size() > 4) void'(mWin.pop_front());
      if (mWin.size() == 4) begin
        sum = 0;
        foreach (mWin[i]) sum += mWin[i];
        mAccPrev = 1;
        mAccVal  = sum / 4;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nBad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    chk("filtTemp",  filtTemp,          8'(mFilt));
    chk("filtValid", {7'd0, filtValid}, 8'(mValid));
    chk("zone",      {6'd0, zone},      8'(mZone));
    chk("fanLevel",  {6'd0, fanLevel},  8'(mZone));
    chk("alarm",     {7'd0, alarm},     8'(mAlarm));
  endtask

  task automatic step(input logic r, input logic sv, input logic [7:0] t, input logic ack);
    rstN = r; sampleValid = sv; temperature = t; alarmAck = ack;
    @(posedge clk);
    modelEdge(r, sv, t, ack);
    #1;
    checkAll();
  endtask

  task automatic feed(input logic [7:0] t, input int n, input logic ack);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, t, ack);
  endtask

  task automatic idle(input int n, input logic ack);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'd0, ack);
  endtask

  task automatic doReset();
    step(1'b0, 1'b0, 8'd0, 1'b0);
  endtask

  int base;
  int tv;

  initial begin
    // Reset with a live sample presented
    step(1'b0, 1'b1, 8'd100, 1'b0);
    step(1'b0, 1'b1, 8'd100, 1'b0);
    chk("rst_filtTemp",  filtTemp, 8'd0);
    chk("rst_filtValid", {7'd0, filtValid}, 8'd0);
    chk("rst_zone",      {6'd0, zone}, 8'd0);
    chk("rst_alarm",     {7'd0, alarm}, 8'd0);

    // Fill: three samples give nothing, fourth produces the first pulse
    feed(8'd50, 3, 1'b0);
    chk("fill3_valid", {7'd0, filtValid}, 8'd0);
    feed(8'd50, 1, 1'b0);
    chk("fill4_edge_valid", {7'd0, filtValid}, 8'd0);
    idle(1, 1'b0);
    chk("fill4_valid", {7'd0, filtValid}, 8'd1);
    chk("fill4_temp",  filtTemp, 8'd50);
    idle(1, 1'b0);
    chk("hold_valid", {7'd0, filtValid}, 8'd0);
    chk("hold_temp",  filtTemp, 8'd50);

    // Averaging with truncation and at full scale
    feed(8'd10, 1, 1'b0); feed(8'd20, 1, 1'b0); feed(8'd30, 1, 1'b0); feed(8'd41, 1, 1'b0);
    idle(1, 1'b0);
    chk("avg_trunc", filtTemp, 8'd25);
    feed(8'd255, 4, 1'b0);
    idle(1, 1'b0);
    chk("avg_max", filtTemp, 8'd255);
    idle(2, 1'b0);

    // Hysteresis around WARM
    doReset();
    feed(8'd45, 8, 1'b0); idle(2, 1'b0);
    chk("hyst_warm", {6'd0, zone}, 8'd1);
    chk("hyst_fan",  {6'd0, fanLevel}, 8'd1);
    feed(8'd38, 8, 1'b0); idle(2, 1'b0);
    chk("hyst_hold", {6'd0, zone}, 8'd1);
    feed(8'd30, 8, 1'b0); idle(2, 1'b0);
    chk("hyst_cool", {6'd0, zone}, 8'd0);

    // Persistence restart: filtered 45,45,30,45,45 then 45
    doReset();
    feed(8'd45, 1, 1'b0); feed(8'd100, 1, 1'b0); feed(8'd0, 1, 1'b0); feed(8'd35, 1, 1'b0);
    feed(8'd45, 1, 1'b0); feed(8'd40, 1, 1'b0); feed(8'd60, 1, 1'b0); feed(8'd35, 1, 1'b0);
    idle(2, 1'b0);
    chk("persist_stay", {6'd0, zone}, 8'd0);
    feed(8'd45, 1, 1'b0); idle(2, 1'b0);
    chk("persist_move", {6'd0, zone}, 8'd1);

    // CRIT entry, ack ignored in CRIT, alarm latched after exit
    doReset();
    feed(8'd20, 4, 1'b0);
    feed(8'd200, 2, 1'b0); idle(2, 1'b0);
    chk("crit_zone",  {6'd0, zone}, 8'd3);
    chk("crit_alarm", {7'd0, alarm}, 8'd1);
    idle(3, 1'b1);
    chk("crit_ack_ignored", {7'd0, alarm}, 8'd1);
    feed(8'd20, 7, 1'b0); idle(2, 1'b0);
    chk("crit_exit_zone",  {6'd0, zone}, 8'd0);
    chk("crit_exit_alarm", {7'd0, alarm}, 8'd1);
    idle(1, 1'b1);
    chk("ack_clears", {7'd0, alarm}, 8'd0);

    // Ack coincident with CRIT entry; reset during a pending count of 2
    doReset();
    feed(8'd20, 4, 1'b0);
    feed(8'd200, 2, 1'b1); idle(2, 1'b1);
    chk("simul_alarm", {7'd0, alarm}, 8'd1);
    feed(8'd20, 5, 1'b0); idle(2, 1'b0);
    chk("pending_still_crit", {6'd0, zone}, 8'd3);
    doReset();
    chk("midrst_zone",  {6'd0, zone}, 8'd0);
    chk("midrst_alarm", {7'd0, alarm}, 8'd0);
    feed(8'd50, 3, 1'b0); idle(2, 1'b0);
    chk("refill_valid", {7'd0, filtValid}, 8'd0);
    chk("refill_temp",  filtTemp, 8'd0);
    feed(8'd50, 1, 1'b0); idle(1, 1'b0);
    chk("refill_pulse", {7'd0, filtValid}, 8'd1);

    // Random walk across the thresholds with sporadic resets and acks
    base = 30;
    for (int i = 0; i < 1500; i++) begin
      base = base + int'($urandom_range(0, 24)) - 12;
      if (base < 0) base = 0;
      if (base > 255) base = 255;
      tv = base + int'($urandom_range(0, 16)) - 8;
      if (tv < 0) tv = 0;
      if (tv > 255) tv = 255;
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 7), 8'(tv),
           ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
